// File: rtl/od_serial_pkg.sv
// Shared definitions for the open-drain serial link: the FSM state encoding
// and the bit-period helpers used by the transmitter and the future receiver.
package od_serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GUARD = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Mid-bit sample point; at least two clocks after any drive change so the
  // two-flop synchronizer has settled.
  function automatic int sample_tick(input int bit_ticks);
    return bit_ticks / 2;
  endfunction

  // Bit period must be even (clean midpoint) and long enough to cover the
  // synchronizer latency before the sample point.
  function automatic bit bit_ticks_ok(input int bit_ticks);
    return (bit_ticks >= 4) && ((bit_ticks % 2) == 0);
  endfunction

endpackage

// File: rtl/od_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset value (an idle open-drain line resets to 1).
module od_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops to resolve metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/od_serial_tx.sv
// Open-drain bit-serial transmitter. Frames a word as start (low), data
// LSB-first, stop (released). Only ever pulls the shared line low or
// releases it, and backs off when another driver wins arbitration.
module od_serial_tx
  import od_serial_pkg::*;
#(
  parameter int BIT_TICKS = 8,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              line_in,
  output logic              line_drv_low,
  output logic              busy,
  output logic              done,
  output logic              arb_lost
);

  localparam int TW          = $clog2(BIT_TICKS) + 1;
  localparam int BW          = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SAMPLE_TICK = sample_tick(BIT_TICKS);

  localparam logic [TW-1:0] TICK_LAST   = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] TICK_SAMPLE = TW'(SAMPLE_TICK);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_W - 1);

  if (!bit_ticks_ok(BIT_TICKS)) begin : g_bad_bit_ticks
    $error("od_serial_tx: BIT_TICKS must be even and >= 4");
  end

  state_t            state;
  logic [TW-1:0]     tick;
  logic [TW-1:0]     guard_cnt;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic              line_s;

  od_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (line_in),
    .q  (line_s)
  );

  // The bit currently on the wire is always shreg[0]; the next one is
  // shreg_next[0].
  assign shreg_next = shreg >> 1;

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Frame sequencer: guard wait, start, data bits, stop, with arbitration
  // checks at the mid-bit sample point of every released bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tick         <= '0;
      guard_cnt    <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      line_drv_low <= 1'b0;
      done         <= 1'b0;
      arb_lost     <= 1'b0;
    end else begin
      done     <= 1'b0;
      arb_lost <= 1'b0;
      case (state)
        IDLE: begin
          line_drv_low <= 1'b0;
          if (tx_valid) begin
            shreg     <= tx_data;
            guard_cnt <= '0;
            state     <= GUARD;
          end
        end
        GUARD: begin
          // Only start once the line has been seen high for a full bit period.
          if (!line_s) begin
            guard_cnt <= '0;
          end else if (guard_cnt == TICK_LAST) begin
            guard_cnt    <= '0;
            tick         <= '0;
            line_drv_low <= 1'b1;
            state        <= START;
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
        START: begin
          if (tick == TICK_LAST) begin
            tick         <= '0;
            bit_idx      <= '0;
            line_drv_low <= ~shreg[0];
            state        <= DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          // Releasing a 1 but reading 0 means another driver owns the line.
          if ((tick == TICK_SAMPLE) && shreg[0] && !line_s) begin
            line_drv_low <= 1'b0;
            arb_lost     <= 1'b1;
            state        <= IDLE;
          end else if (tick == TICK_LAST) begin
            tick <= '0;
            if (bit_idx == BIT_LAST) begin
              line_drv_low <= 1'b0;
              state        <= STOP;
            end else begin
              bit_idx      <= bit_idx + 1'b1;
              shreg        <= shreg_next;
              line_drv_low <= ~shreg_next[0];
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        STOP: begin
          if ((tick == TICK_SAMPLE) && !line_s) begin
            arb_lost <= 1'b1;
            state    <= IDLE;
          end else if (tick == TICK_LAST) begin
            tick  <= '0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: begin
          line_drv_low <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_od_serial_tx.sv
// Bench for od_serial_tx: open-drain pad plus pull-up and a second contender
// driver on one wired-AND line. Stimulus pushes expected frames into a queue;
// an independent monitor pops and checks on every done/arb_lost pulse.
module tb_od_serial_tx;

  localparam int BT     = 8;
  localparam int DW     = 8;
  localparam int SAMPLE = BT / 2;
  localparam int FRAME  = (DW + 2) * BT;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          line_drv_low;
  logic          busy;
  logic          done;
  logic          arb_lost;
  logic          cont_low;

  // Shared line: weak pull-up, our pad and a contender can only pull low.
  wire line;
  pullup (line);
  assign line = line_drv_low ? 1'b0 : 1'bz;
  assign line = cont_low     ? 1'b0 : 1'bz;

  od_serial_tx #(
    .BIT_TICKS(BT),
    .DATA_W   (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .line_in     (line),
    .line_drv_low(line_drv_low),
    .busy        (busy),
    .done        (done),
    .arb_lost    (arb_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] w;
    int            cs;         // slot the contender pulls low in, -1 = none
    bit            chk_guard;  // idle line: expect exactly BT guard clocks
  } exp_t;

  exp_t exp_q[$];

  // Wire level this transmitter wants in frame slot s (0 start, 1..DW data, DW+1 stop).
  function automatic bit slot_level(input logic [DW-1:0] w, input int s);
    if (s == 0) return 1'b0;
    if (s <= DW) return w[s-1];
    return 1'b1;
  endfunction

  // Outcome: a contender in a slot where we release the line wins at that
  // slot's mid-bit check; the pulse follows one clock later.
  function automatic void predict(input logic [DW-1:0] w, input int cs,
                                  output bit arb, output int endc);
    arb  = (cs >= 1) && slot_level(w, cs);
    endc = arb ? (cs * BT + SAMPLE + 1) : FRAME;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit in_frame, start_seen, busy_prev, done_prev, arb_prev;
  int acc_cyc, start_cyc;
  bit drv_log [0:255];

  always @(negedge clk) begin
    exp_t e;
    bit   arb;
    int   endc;
    int   bad;
    int   off;
    if (rst) begin
      in_frame   = 1'b0;
      start_seen = 1'b0;
      busy_prev  = 1'b0;
      done_prev  = 1'b0;
      arb_prev   = 1'b0;
      if (done || arb_lost) check("pulse_during_reset", 1, 0);
    end else begin
      if (done || arb_lost) check("pulse_exclusive", int'(done && arb_lost), 0);
      if (done_prev) check("done_one_cycle", int'(done), 0);
      if (arb_prev) check("arb_one_cycle", int'(arb_lost), 0);
      if (busy && !busy_prev) begin
        in_frame   = 1'b1;
        start_seen = 1'b0;
        acc_cyc    = cyc;
      end
      if (in_frame && !start_seen && line_drv_low) begin
        start_seen = 1'b1;
        start_cyc  = cyc;
        if (exp_q.size() > 0 && exp_q[0].chk_guard)
          check("guard_clks", cyc - acc_cyc, BT);
      end
      if (start_seen) begin
        off = cyc - start_cyc;
        if (off < 256) drv_log[off] = line_drv_low;
      end
      if (done || arb_lost) begin
        if (exp_q.size() == 0 || !start_seen) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          predict(e.w, e.cs, arb, endc);
          off = cyc - start_cyc;
          check("outcome_arb_lost", int'(arb_lost), int'(arb));
          check("start_to_pulse_clks", off, endc);
          bad = 0;
          for (int k = 0; k < endc && k < off && k < 256; k++)
            if (drv_log[k] != !slot_level(e.w, k / BT)) bad++;
          check("drv_pattern_errs", bad, 0);
          check("drv_released_at_end", int'(line_drv_low), 0);
          check("ready_at_end", int'(tx_ready), 1);
        end
        in_frame   = 1'b0;
        start_seen = 1'b0;
      end
      busy_prev = busy;
      done_prev = done;
      arb_prev  = arb_lost;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [DW-1:0] w, input int cs, input bit chk_guard,
                       input bit push, input bit hold_valid);
    exp_t e;
    int   n;
    e.w = w; e.cs = cs; e.chk_guard = chk_guard;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 50);
    if (!busy) check("accept_timeout", 0, 1);
    if (!hold_valid) tx_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!line_drv_low && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!line_drv_low) check("start_timeout", 0, 1);
  endtask

  // Follows a frame from START, pulling the line low in contender slot cs.
  task automatic run_frame(input int cs);
    int n;
    wait_start();
    for (n = 0; n < FRAME + 40; n++) begin
      if (cs >= 0 && n == cs * BT + 1) cont_low = 1'b1;
      if (cs >= 0 && n == cs * BT + 4) cont_low = 1'b0;
      if (!busy && n > 0 && n > cs * BT + 4) break;
      @(negedge clk);
    end
    cont_low = 1'b0;
    if (busy) check("frame_end_timeout", 0, 1);
    wait_negs(3);
  endtask

  initial begin
    int m;
    int bad;
    rst      = 1'b1;
    tx_data  = '0;
    tx_valid = 1'b0;
    cont_low = 1'b0;
    wait_negs(3);
    check("rst_tx_ready", int'(tx_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_drv", int'(line_drv_low), 0);
    check("rst_done", int'(done), 0);
    check("rst_arb", int'(arb_lost), 0);
    rst = 1'b0;
    wait_negs(4);

    // 1: plain frame on an idle line
    issue(8'hA5, -1, 1'b1, 1'b1, 1'b0);
    run_frame(-1);

    // 2: line held low by contender stalls the guard
    cont_low = 1'b1;
    wait_negs(5);
    issue(8'h3C, -1, 1'b0, 1'b1, 1'b0);
    bad = 0;
    repeat (14) begin
      @(negedge clk);
      if (line_drv_low) bad++;
    end
    check("no_drive_while_line_low", bad, 0);
    cont_low = 1'b0;
    m = 0;
    while (!line_drv_low && m < 100) begin
      @(negedge clk);
      m++;
    end
    check("release_to_start_clks", m, BT + 2);
    run_frame(-1);

    // 3: contender wins during data bit 2
    issue(8'hFF, 3, 1'b1, 1'b1, 1'b0);
    run_frame(3);

    // 4: contender low only at the stop-bit sample point
    issue(8'h00, DW + 1, 1'b1, 1'b1, 1'b0);
    run_frame(DW + 1);

    // 5: reset in the middle of data bit 4
    issue(8'h00, -1, 1'b1, 1'b0, 1'b0);
    wait_start();
    wait_negs(5 * BT + 3);
    check("drv_before_reset", int'(line_drv_low), 1);
    rst = 1'b1;
    #1;
    check("drv_async_reset", int'(line_drv_low), 0);
    wait_negs(2);
    rst = 1'b0;
    wait_negs(1);
    check("post_reset_ready", int'(tx_ready), 1);
    check("post_reset_busy", int'(busy), 0);
    wait_negs(20);

    // 6: back-to-back words with tx_valid held high
    issue(8'h01, -1, 1'b1, 1'b1, 1'b1);
    tx_data = 8'h80;
    exp_q.push_back('{w: 8'h80, cs: -1, chk_guard: 1'b1});
    m = 0;
    while (!done && m < 200) begin
      @(negedge clk);
      m++;
    end
    check("b2b_first_done_seen", int'(done), 1);
    @(negedge clk);
    check("b2b_accept_after_done", int'(busy), 1);
    tx_valid = 1'b0;
    run_frame(-1);

    // randomized frames with a random contender slot
    repeat (12) begin
      logic [DW-1:0] w;
      int cs;
      w  = DW'($urandom);
      cs = int'($urandom_range(DW + 2, 0)) - 1;
      issue(w, cs, 1'b1, 1'b1, 1'b0);
      run_frame(cs);
    end

    wait_negs(5);
    check("leftover_expected", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/od_serial_tx.md
Name: od_serial_tx

Overview:
- Open-drain, bit-serial transmitter for a single shared wired-AND line with a weak pull-up.
- It is the driving end of the pull-resistor bus that the strength tests exercise. It only ever drives strong0 or releases the line. It never drives 1.
- It frames a DATA_W-bit word as start, data LSB-first, then stop.
- It detects loss of arbitration by sampling the line it shares with other open-drain drivers.
- It sits between a valid/ready producer and the top-level pad. The pad is a `bufif1 (strong0, highz1)` plus `pullup`.

Parameters:
- BIT_TICKS, 8, clocks per bit period. Must be even and ≥4.
- DATA_W, 8, payload bits per frame.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  DATA_W  word to send. Captured on accept.
- tx_valid  input  1  producer has a word.
- tx_ready  output  1  high only in IDLE. Accept happens when tx_valid && tx_ready at a rising edge.
- line_in  input  1  resolved line value, asynchronous to clk.
- line_drv_low  output  1  1 = pad drives strong0, 0 = release (pull-up wins). Registered.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a frame completes without arbitration loss.
- arb_lost  output  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset values (asynchronous, while rst=1):
  - state=IDLE, tx_ready=1, line_drv_low=0, busy=0, done=0, arb_lost=0.
  - Synchronizer flops = 1. Counters and shift register = 0.
- line_in passes through a 2-flop synchronizer to give line_s. All checks use line_s.
- tick counter counts 0..BIT_TICKS-1. The sample point is tick==BIT_TICKS/2. This is ≥2 cycles after a drive change, which covers synchronizer latency.
- IDLE:
  - tx_ready=1.
  - On accept: latch tx_data into shift register, clear guard counter, go to GUARD.
- GUARD:
  - Line released.
  - Guard counter increments each cycle line_s=1 and clears to 0 when line_s=0.
  - When it reaches BIT_TICKS, go to START with tick=0 and line_drv_low=1 on the same edge.
- START:
  - line_drv_low=1 for BIT_TICKS cycles.
  - No check in this state.
  - Then go to DATA with bit index 0.
- DATA:
  - For each bit i (0..DATA_W-1), line_drv_low = ~data[i] for BIT_TICKS cycles.
  - At the sample point, if data[i]=1 and line_s=0:
    - next edge: line_drv_low=0, arb_lost pulse, state=IDLE;
    - remaining bits are discarded.
  - After bit DATA_W-1, go to STOP.
- STOP:
  - Line released for BIT_TICKS cycles.
  - At the sample point, line_s=0 is treated as arbitration loss: arb_lost pulse, go to IDLE.
  - At tick BIT_TICKS-1 end: done pulse on the edge entering IDLE.
- done and arb_lost are never high together. Each is exactly one cycle.
- Frame duration from START entry to done: (DATA_W+2)*BIT_TICKS cycles. For the defaults this is 80.
- Minimum accept-to-START is BIT_TICKS cycles with an idle line. A held-low line stalls GUARD indefinitely.
- tx_valid is ignored while busy. A new word can be accepted in the cycle after done or arb_lost.
- Reset mid-frame:
  - line_drv_low drops to 0 immediately (asynchronously).
  - The frame is lost with no done or arb_lost pulse.
- The bit counter is sized for DATA_W. The tick counter is sized $clog2(BIT_TICKS)+1. Neither counter wraps inside a frame.

Decomposition:
- Shared package/include od_serial_pkg:
  - state encodings: IDLE, GUARD, START, DATA, STOP;
  - localparam SAMPLE_TICK = BIT_TICKS/2;
  - elaboration-time check that BIT_TICKS is even and ≥4.
- One sub-module, od_sync2: 2-flop synchronizer with reset value parameter (1 here). It is reused by the future receiver.

Test Plan:
- Bench: pullup on the line plus a `bufif1 (strong0, highz1)` pad, with a second contender driver. The defaults apply: BIT_TICKS=8, DATA_W=8.
- 1. Send 8'hA5 on an idle line: line low 8 clks, then pattern 1,0,1,0,0,1,0,1 at 8 clks each, then released 8 clks. done pulses once, 80 clks after START, with arb_lost=0.
- 2. Hold the contender low 20 clks, then present tx_valid with 8'h3C: GUARD waits until the line has been high 8 consecutive clks. No low drive appears before that.
- 3. Send 8'hFF while the contender drives low during bit 2: arb_lost pulses once, and line_drv_low=0 within 1 clk after the sample point. There is no done pulse, and tx_ready=1 the following cycle.
- 4. Contender pulls low only during the STOP sample point of 8'h00: arb_lost pulses, with no done pulse.
- 5. Assert rst at bit 4 of a frame: line_drv_low=0 in the same timestep. After release: tx_ready=1, busy=0, no pulses.
- 6. Back-to-back: tx_valid held high with 8'h01 then 8'h80. The second word is accepted 1 clk after done. Both frames are correct, with 8 guard clks between them.
